ps2_keypad_decoder: RTL and testbench
=====================================

Name: ps2_keypad_decoder

Overview:
- Synchronous, parametrised successor to the top-level PS/2 scancode-to-keypad logic.
- Converts the byte stream from the PS/2 receiver into the 16-key Chip-8 matrix.
- Supports break (F0) and extended (E0) prefixes, two selectable layouts and duplicate-make (typematic) filtering.
- Queues press/release events in a FIFO for the CPU's wait-for-key instruction. Sits between ps2in and the CPU keyMatrix input.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronising ps2_ready into clk (min 2).
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).
- TYPEMATIC_FILTER, 1, 1 = make code for an already-pressed key produces no event.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ps2_ready  in  1  byte strobe from the PS/2 receiver, asynchronous to clk; a rising edge marks a new byte.
- ps2_data  in  8  scancode byte, stable while ps2_ready is high.
- layout  in  1  0 = QWERTY block (1234/QWER/ASDF/ZXCV), 1 = numeric keypad.
- clear  in  1  synchronous pulse: flush state.
- key_matrix  out  16  bit k = Chip-8 key k held.
- any_key  out  1  OR of key_matrix (registered).
- evt_valid  out  1  FIFO non-empty.
- evt_key  out  4  key index of the head event.
- evt_pressed  out  1  1 = press, 0 = release (head event).
- evt_pop  in  1  pops the head when evt_valid is high; ignored when empty.
- evt_count  out  $clog2(FIFO_DEPTH+1)  entries queued.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in IDLE, FIFO empty, synchroniser cleared.
- Byte strobe: ps2_ready passes SYNC_STAGES flops; a rising edge of the synchronised signal latches ps2_data into a byte register and raises a one-cycle strobe. The FSM, matrix and FIFO update on the next edge. Total latency is SYNC_STAGES+2 clk edges from the first edge that samples ps2_ready high.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0 -> BRK; E0 -> EXT; AA -> clear matrix, stay; any other byte -> make(code, ext=0).
  - BRK: any byte -> break(code, ext=0) -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> make(code, ext=1) -> IDLE.
  - EXT_BRK: any byte -> break(code, ext=1) -> IDLE.
  - E1, FA, FE, EE in IDLE are ignored. Unmapped codes cause no matrix or FIFO change.
- Layout 0 map (ext=0 only): 16->1, 1E->2, 26->3, 25->C, 15->4, 1D->5, 24->6, 2D->D, 1C->7, 1B->8, 23->9, 2B->E, 1A->A, 22->0, 21->B, 2A->F. Extended codes are unmapped.
- Layout 1 map:
  - ext=0: 70->0, 69->1, 72->2, 7A->3, 6B->4, 73->5, 74->6, 6C->7, 75->8, 7D->9, 79->A, 7B->B, 7C->C, 71->F.
  - ext=1: 4A->D, 5A->E.
- Layout change (layout differs from its previous-cycle registered value): matrix cleared, FSM -> IDLE, FIFO retained.
- make: sets matrix bit. Pushes {key,1} unless TYPEMATIC_FILTER=1 and the bit was already set.
- break: clears matrix bit. Pushes {key,0} only if the bit was set (no release event for a key not held).
- FIFO:
  - Head is visible combinationally from registered storage.
  - Push and pop in the same cycle are both honoured, including when full and when empty-with-push (the pop is ignored because evt_valid is 0).
  - Push while full without a pop: event dropped, overflow set.
  - Pointers wrap modulo FIFO_DEPTH.
- clear: matrix, any_key, FSM, FIFO, overflow -> 0 on the next edge. It takes priority over a coincident byte strobe, whose byte is discarded.
- any_key reflects key_matrix in the same cycle (both registered together).

Test Plan:
- Layout 0, bytes 1D then F0 1D -> key_matrix=0x0020, event {5,1}. Then key_matrix=0x0000, event {5,0}. evt_count=2. Pop twice -> evt_valid=0.
- Layout 1, bytes E0 5A, E0 F0 5A, then plain 5A -> E0 5A sets bit E (0x4000). E0 F0 5A clears it. Plain 5A (unmapped) -> no change, evt_count=2.
- TYPEMATIC_FILTER=1, bytes 16 16 16 -> one event {1,1}, key_matrix=0x0002. With TYPEMATIC_FILTER=0 -> three events.
- FIFO_DEPTH=4, six distinct makes, no pops -> evt_count=4, overflow=1, head={first key,1}. Assert pop together with a 7th push -> count stays 4, newest event stored.
- Press 22 (key 0), toggle layout -> key_matrix=0, FSM IDLE. Send F0 22 in layout 1 -> no event (bit was not set).
- Assert rst_n=0 mid-sequence after E0 F0 -> all outputs 0. Then byte 1A -> treated as a fresh make from IDLE, key_matrix=0x0400.

Source files
------------

// File: rtl/ps2_keypad_decoder.sv
// PS/2 scancode stream to Chip-8 16-key matrix, with break/extended prefix
// handling, two key layouts and a press/release event FIFO for the CPU.
module ps2_keypad_decoder #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter bit          TYPEMATIC_FILTER = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ps2_ready,
  input  logic [7:0]                         ps2_data,
  input  logic                               layout,
  input  logic                               clear,
  output logic [15:0]                        key_matrix,
  output logic                               any_key,
  output logic                               evt_valid,
  output logic [3:0]                         evt_key,
  output logic                               evt_pressed,
  input  logic                               evt_pop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    evt_count,
  output logic                               overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BRK     = 2'd1;
  localparam logic [1:0] EXT     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   strobe;
  logic [7:0]             byte_q;
  logic                   layout_q;
  logic                   rise_c;
  logic                   layout_chg_c;

  assign rise_c       = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign layout_chg_c = layout ^ layout_q;

  // Bring the receiver strobe into clk and capture the byte on its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      strobe    <= 1'b0;
      byte_q    <= '0;
      layout_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ps2_ready};
      sync_prev <= sync_q[SYNC_STAGES-1];
      strobe    <= rise_c;
      layout_q  <= layout;
      if (rise_c) byte_q <= ps2_data;
    end
  end

  // Returns {hit, key} for a scancode in the selected layout.
  function automatic logic [4:0] map_code(input logic [7:0] code, input logic ext,
                                          input logic lay);
    logic [4:0] r;
    r = 5'h00;
    if (!lay && !ext) begin
      case (code)
        8'h22: r = 5'h10;  8'h16: r = 5'h11;  8'h1E: r = 5'h12;  8'h26: r = 5'h13;
        8'h15: r = 5'h14;  8'h1D: r = 5'h15;  8'h24: r = 5'h16;  8'h1C: r = 5'h17;
        8'h1B: r = 5'h18;  8'h23: r = 5'h19;  8'h1A: r = 5'h1A;  8'h21: r = 5'h1B;
        8'h25: r = 5'h1C;  8'h2D: r = 5'h1D;  8'h2B: r = 5'h1E;  8'h2A: r = 5'h1F;
        default: r = 5'h00;
      endcase
    end else if (lay && !ext) begin
      case (code)
        8'h70: r = 5'h10;  8'h69: r = 5'h11;  8'h72: r = 5'h12;  8'h7A: r = 5'h13;
        8'h6B: r = 5'h14;  8'h73: r = 5'h15;  8'h74: r = 5'h16;  8'h6C: r = 5'h17;
        8'h75: r = 5'h18;  8'h7D: r = 5'h19;  8'h79: r = 5'h1A;  8'h7B: r = 5'h1B;
        8'h7C: r = 5'h1C;  8'h71: r = 5'h1F;
        default: r = 5'h00;
      endcase
    end else if (lay && ext) begin
      case (code)
        8'h4A: r = 5'h1D;
        8'h5A: r = 5'h1E;
        default: r = 5'h00;
      endcase
    end
    return r;
  endfunction

  logic [1:0]  state, state_next;
  logic [15:0] matrix_next;
  logic        push;
  logic [4:0]  push_evt;
  logic [4:0]  hit;
  logic        do_make, do_break;

  // Prefix FSM plus matrix update and event generation.
  always_comb begin
    state_next  = state;
    matrix_next = key_matrix;
    push        = 1'b0;
    push_evt    = '0;
    do_make     = 1'b0;
    do_break    = 1'b0;
    hit         = map_code(byte_q, (state == EXT) || (state == EXT_BRK), layout);
    if (clear || layout_chg_c) begin
      state_next  = IDLE;
      matrix_next = '0;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          case (byte_q)
            8'hF0:                     state_next = BRK;
            8'hE0:                     state_next = EXT;
            8'hAA:                     matrix_next = '0;
            8'hE1, 8'hFA, 8'hFE, 8'hEE: begin end
            default:                   do_make = 1'b1;
          endcase
        end
        BRK: begin
          do_break   = 1'b1;
          state_next = IDLE;
        end
        EXT: begin
          if (byte_q == 8'hF0) begin
            state_next = EXT_BRK;
          end else begin
            do_make    = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          do_break   = 1'b1;
          state_next = IDLE;
        end
      endcase
      if (do_make && hit[4]) begin
        matrix_next[hit[3:0]] = 1'b1;
        if (!(TYPEMATIC_FILTER && key_matrix[hit[3:0]])) begin
          push     = 1'b1;
          push_evt = {hit[3:0], 1'b1};
        end
      end
      if (do_break && hit[4] && key_matrix[hit[3:0]]) begin
        matrix_next[hit[3:0]] = 1'b0;
        push     = 1'b1;
        push_evt = {hit[3:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_matrix <= '0;
      any_key    <= 1'b0;
    end else begin
      state      <= state_next;
      key_matrix <= matrix_next;
      any_key    <= |matrix_next;
    end
  end

  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop_c, full_c, push_ok_c;
  logic [CW-1:0] count_next_c;

  assign pop_c        = evt_pop & evt_valid;
  assign full_c       = (evt_count == CW'(FIFO_DEPTH));
  assign push_ok_c    = push & (~full_c | pop_c);
  assign count_next_c = evt_count + CW'(push_ok_c) - CW'(pop_c);
  assign evt_key      = mem[rd_ptr][4:1];
  assign evt_pressed  = mem[rd_ptr][0];

  // Event FIFO; a pop frees the slot a coincident push needs when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= push_evt;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      if (push && !push_ok_c) overflow <= 1'b1;
      evt_count <= count_next_c;
      evt_valid <= (count_next_c != '0);
    end
  end

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Randomised and directed bench for ps2_keypad_decoder against a scancode-level
// reference model (prefix flags, lookup tables and an event queue).
module tb_ps2_keypad_decoder;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEPTH = 4;
  localparam bit          FILT  = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n, ps2_ready, layout, clear, evt_pop;
  logic [7:0]  ps2_data;
  logic [15:0] key_matrix;
  logic        any_key, evt_valid, evt_pressed, overflow;
  logic [3:0]  evt_key;
  logic [2:0]  evt_count;

  ps2_keypad_decoder #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .TYPEMATIC_FILTER(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
    .layout(layout), .clear(clear), .key_matrix(key_matrix), .any_key(any_key),
    .evt_valid(evt_valid), .evt_key(evt_key), .evt_pressed(evt_pressed),
    .evt_pop(evt_pop), .evt_count(evt_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Key tables indexed by key number; 00 means no code for that key.
  logic [7:0] map0  [16] = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
                             8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
  logic [7:0] map1  [16] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                             8'h75, 8'h7D, 8'h79, 8'h7B, 8'h7C, 8'h00, 8'h00, 8'h71};
  logic [7:0] map1e [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h4A, 8'h5A, 8'h00};
  logic [7:0] pool  [39] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h15, 8'h1D, 8'h24, 8'h2D,
                             8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h1A, 8'h22, 8'h21, 8'h2A,
                             8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                             8'h75, 8'h7D, 8'h79, 8'h7B, 8'h7C, 8'h71, 8'h4A, 8'h5A,
                             8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'hAA, 8'hFA, 8'hE1};

  logic [15:0] m_mat;
  bit          m_brk, m_ext, m_ovf, m_lay;
  logic [4:0]  m_q[$];

  function automatic int lookup(input logic [7:0] b, input bit ext, input bit lay);
    if (b == 8'h00) return -1;
    for (int k = 0; k < 16; k++) begin
      if (!lay && !ext && map0[k] == b) return k;
      if (lay && !ext && map1[k] == b) return k;
      if (lay && ext && map1e[k] == b) return k;
    end
    return -1;
  endfunction

  function automatic void m_push(input logic [4:0] ev);
    if (m_q.size() < DEPTH) m_q.push_back(ev);
    else m_ovf = 1'b1;
  endfunction

  function automatic void m_clear();
    m_mat = '0; m_brk = 0; m_ext = 0; m_ovf = 0; m_q.delete();
  endfunction

  function automatic void m_make(input logic [7:0] b, input bit ext, input bit lay);
    int k = lookup(b, ext, lay);
    if (k >= 0) begin
      if (!(FILT && m_mat[k])) m_push({4'(k), 1'b1});
      m_mat[k] = 1'b1;
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b, input bit lay);
    int k;
    if (m_brk) begin
      k = lookup(b, m_ext, lay);
      if (k >= 0 && m_mat[k]) begin
        m_mat[k] = 1'b0;
        m_push({4'(k), 1'b0});
      end
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else begin m_make(b, 1, lay); m_ext = 0; end
    end else begin
      case (b)
        8'hF0: m_brk = 1;
        8'hE0: m_ext = 1;
        8'hAA: m_mat = '0;
        8'hE1, 8'hFA, 8'hFE, 8'hEE: ;
        default: m_make(b, 0, lay);
      endcase
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".matrix"}, 32'(key_matrix), 32'(m_mat));
    check({tag, ".any"}, 32'(any_key), 32'(m_mat != 16'h0));
    check({tag, ".count"}, 32'(evt_count), 32'(m_q.size()));
    check({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      check({tag, ".key"}, 32'(evt_key), 32'(m_q[0][4:1]));
      check({tag, ".pressed"}, 32'(evt_pressed), 32'(m_q[0][0]));
    end
  endtask

  // mode 0: plain byte, 1: pop coincident with update, 2: clear coincident with strobe
  task automatic send_byte(input logic [7:0] b, input int mode);
    logic [15:0] old = m_mat;
    ps2_data  = b;
    ps2_ready = 1'b1;
    repeat (SYNC + 1) tick();
    check("latency_hold", 32'(key_matrix), 32'(old));
    if (mode == 1) evt_pop = 1'b1;
    if (mode == 2) clear = 1'b1;
    tick();
    evt_pop = 1'b0;
    clear   = 1'b0;
    if (mode == 2) m_clear();
    else begin
      if (mode == 1 && m_q.size() != 0) void'(m_q.pop_front());
      m_byte(b, m_lay);
    end
    compare_all("byte");
    ps2_ready = 1'b0;
    repeat (SYNC + 1) tick();
  endtask

  task automatic pop_one();
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
    compare_all("pop");
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
    compare_all("clear");
  endtask

  task automatic set_layout(input bit v);
    layout = v;
    tick();
    if (v != m_lay) begin m_mat = '0; m_brk = 0; m_ext = 0; end
    m_lay = v;
    compare_all("layout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_clear();
    compare_all("reset");
    check("reset.key", 32'(evt_key), 32'h0);
    check("reset.pressed", 32'(evt_pressed), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    ps2_ready = 0; ps2_data = 0; layout = 0; clear = 0; evt_pop = 0; rst_n = 1;
    m_lay = 0;
    tick();
    do_reset();

    // Layout 0 make then break of key 5
    send_byte(8'h1D, 0);
    check("make5.matrix", 32'(key_matrix), 32'h0020);
    send_byte(8'hF0, 0);
    send_byte(8'h1D, 0);
    check("brk5.matrix", 32'(key_matrix), 32'h0000);
    check("brk5.count", 32'(evt_count), 32'd2);
    pop_one();
    pop_one();
    check("drained", 32'(evt_valid), 32'd0);

    // Layout 1 extended keys
    set_layout(1'b1);
    send_byte(8'hE0, 0); send_byte(8'h5A, 0);
    check("ext.make", 32'(key_matrix), 32'h4000);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h5A, 0);
    send_byte(8'h5A, 0);
    check("ext.count", 32'(evt_count), 32'd2);
    set_layout(1'b0);
    pulse_clear();

    // Typematic repeats
    repeat (3) send_byte(8'h16, 0);
    check("typ.count", 32'(evt_count), 32'd1);
    check("typ.matrix", 32'(key_matrix), 32'h0002);
    pulse_clear();

    // FIFO overflow, then pop alongside a push while full
    send_byte(8'h16, 0); send_byte(8'h1E, 0); send_byte(8'h26, 0);
    send_byte(8'h25, 0); send_byte(8'h15, 0); send_byte(8'h1D, 0);
    check("ovf.count", 32'(evt_count), 32'd4);
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.head", 32'(evt_key), 32'd1);
    send_byte(8'h24, 1);
    check("ovf.popcount", 32'(evt_count), 32'd4);
    check("ovf.newhead", 32'(evt_key), 32'd2);
    repeat (4) pop_one();
    pulse_clear();

    // Layout toggle drops held keys; stale release gives no event
    send_byte(8'h22, 0);
    pop_one();
    set_layout(1'b1);
    send_byte(8'hF0, 0); send_byte(8'h22, 0);
    check("stale.count", 32'(evt_count), 32'd0);
    set_layout(1'b0);

    // Clear coincident with a strobe discards the byte
    send_byte(8'h16, 2);
    check("clrstb.matrix", 32'(key_matrix), 32'h0000);

    // Reset in the middle of an extended-break prefix
    send_byte(8'hE0, 0); send_byte(8'hF0, 0);
    do_reset();
    send_byte(8'h1A, 0);
    check("postrst.matrix", 32'(key_matrix), 32'h0400);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      logic [7:0] b;
      int mode;
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 38)];
      mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 39) == 0) ? 2 : 0);
      send_byte(b, mode);
      if ($urandom_range(0, 2) == 0) pop_one();
      if ($urandom_range(0, 19) == 0) set_layout(~m_lay);
      if ($urandom_range(0, 59) == 0) pulse_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
